// File: rtl/class_pkg.sv
// Shared constants for the class argmax block: sizing, the most negative
// score, and the frame-state encoding.
package class_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 26;
  localparam int IDX_W       = 4;

  // Most negative representable score, used as "no second-best yet".
  localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Index of the final sample of a frame.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  // Frame state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/class_argmax_if.sv
// Sample input and result output bundle of the class argmax block.
interface class_argmax_if;
  import class_pkg::*;

  logic                     Frame_start;
  logic                     In_valid;
  logic signed [DATA_W-1:0] In_data;
  logic        [IDX_W-1:0]  Class_out;
  logic signed [DATA_W-1:0] Max_value;
  logic        [DATA_W-1:0] Margin;
  logic                     Class_valid;
  logic                     Busy;

  // Producer side: drives samples and frame control, observes results.
  modport master (
    output Frame_start, In_valid, In_data,
    input  Class_out, Max_value, Margin, Class_valid, Busy
  );

  // Argmax side: consumes samples, produces results.
  modport slave (
    input  Frame_start, In_valid, In_data,
    output Class_out, Max_value, Margin, Class_valid, Busy
  );

endinterface

// File: rtl/class_argmax_top2_tracker.sv
// Running best / second-best tracker. Exposes its next-state values so the
// parent can register a frame result in the same edge as the final update.
module top2_tracker
  import class_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     load_first,
  input  logic                     update,
  input  logic signed [DATA_W-1:0] din,
  input  logic        [IDX_W-1:0]  din_idx,
  output logic signed [DATA_W-1:0] best_nxt,
  output logic signed [DATA_W-1:0] second_nxt,
  output logic        [IDX_W-1:0]  idx_nxt
);

  logic signed [DATA_W-1:0] best_q;
  logic signed [DATA_W-1:0] second_q;
  logic        [IDX_W-1:0]  idx_q;

  // Next-value selection: a first sample wins over a clear, which wins over an update.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    best_nxt   = best_q;
    second_nxt = second_q;
    idx_nxt    = idx_q;
    if (load_first) begin
      best_nxt   = din;
      second_nxt = SCORE_MIN;
      idx_nxt    = '0;
    end else if (clear) begin
      best_nxt   = SCORE_MIN;
      second_nxt = SCORE_MIN;
      idx_nxt    = '0;
    end else if (update) begin
      // Strict compare: a tie with best keeps the earlier index and makes second equal best.
      if (din > best_q) begin
        second_nxt = best_q;
        best_nxt   = din;
        idx_nxt    = din_idx;
      end else if (din > second_q) begin
        second_nxt = din;
      end
    end
  end

  // Tracker registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; it is not in the sensitivity list.
    if (!rst_n) begin
      best_q   <= SCORE_MIN;
      second_q <= SCORE_MIN;
      idx_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      best_q   <= best_nxt;
      second_q <= second_nxt;
      idx_q    <= idx_nxt;
    end
  end

endmodule

// File: rtl/class_argmax.sv
// Per-frame argmax over NUM_CLASSES signed neuron results: sample counter,
// frame FSM and result registers around a top-2 tracker.
module class_argmax
  import class_pkg::*;
(
  input  logic           clk,
  input  logic           GlobalReset,
  class_argmax_if.slave  bus
);

  logic [1:0]               state_q, state_d;
  logic [IDX_W-1:0]         count_q, count_d;
  logic                     load_first, update, clear, frame_done;
  logic signed [DATA_W-1:0] best_nxt, second_nxt;
  logic        [IDX_W-1:0]  idx_nxt;
  logic        [IDX_W-1:0]  class_q;
  logic signed [DATA_W-1:0] max_q;
  logic        [DATA_W-1:0] margin_q;
  logic        [DATA_W-1:0] margin_nxt;

  top2_tracker u_tracker (
    .clk        (clk),
    .rst_n      (GlobalReset),
    .clear      (clear),
    .load_first (load_first),
    .update     (update),
    .din        (bus.In_data),
    .din_idx    (count_q),
    .best_nxt   (best_nxt),
    .second_nxt (second_nxt),
    .idx_nxt    (idx_nxt)
  );

  // Frame sequencing: sample acceptance, counter advance, abort and completion.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    load_first = 1'b0;
    update     = 1'b0;
    clear      = 1'b0;
    frame_done = 1'b0;
    if (bus.Frame_start) begin
      // Abort: drop the partial frame; a coincident sample opens the new one.
      clear = 1'b1;
      if (bus.In_valid) begin
        load_first = 1'b1;
        count_d    = IDX_W'(1);
        state_d    = ST_ACCUM;
      end else begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    end else if (bus.In_valid) begin
      load_first = (count_q == '0);
      update     = (count_q != '0);
      if (count_q == LAST_IDX) begin
        count_d    = '0;
        state_d    = ST_DONE;
        frame_done = 1'b1;
      end else begin
        count_d = count_q + IDX_W'(1);
        state_d = ST_ACCUM;
      end
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end

  // best >= second always holds and the true difference lies in 0..2^DATA_W-1,
  // so the DATA_W-bit wrap-around difference equals the exact DATA_W+1-bit result.
  assign margin_nxt = DATA_W'(best_nxt) - DATA_W'(second_nxt);

  // Counter, state and result registers; results load only on frame completion.
  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      class_q  <= '0;
      max_q    <= '0;
      margin_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (frame_done) begin
        class_q  <= idx_nxt;
        max_q    <= best_nxt;
        margin_q <= margin_nxt;
      end
    end
  end

  assign bus.Class_out   = class_q;
  assign bus.Max_value   = max_q;
  assign bus.Margin      = margin_q;
  assign bus.Class_valid = (state_q == ST_DONE);
  assign bus.Busy        = (count_q != '0);

endmodule
